alu_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/alu_sequencer_if.sv | 34 +++
 rtl/alu_sequencer_alu.sv | 54 +++++
 rtl/alu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions for the ALU sequencer: op codes,
//               flag-mask bit positions, sequencer states and the
//               op-to-flag-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // ALU micro-op codes; 12..15 are treated as NOP by the sequencer
  typedef enum logic [3:0] {
    OP_ADC = 4'd0,
    OP_SBC = 4'd1,
    OP_AND = 4'd2,
    OP_ORA = 4'd3,
    OP_EOR = 4'd4,
    OP_ASL = 4'd5,
    OP_LSR = 4'd6,
    OP_ROL = 4'd7,
    OP_ROR = 4'd8,
    OP_CMP = 4'd9,
    OP_INC = 4'd10,
    OP_DEC = 4'd11
  } alu_op_e;

  // Bit positions inside the {N,Z,C,V} flag mask
  localparam int FM_N = 3;
  localparam int FM_Z = 2;
  localparam int FM_C = 1;
  localparam int FM_V = 0;

  localparam logic [3:0] MASK_NZCV = 4'b1111;
  localparam logic [3:0] MASK_NZC  = 4'b1110;
  localparam logic [3:0] MASK_NZ   = 4'b1100;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2
  } seq_state_e;

  // Which status flags an op writes back
  function automatic logic [3:0] flag_mask_f(input logic [3:0] op);
    logic [3:0] m;
    case (op)
      OP_ADC, OP_SBC:                          m = MASK_NZCV;
      OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC:  m = MASK_NZ;
      OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_CMP:  m = MASK_NZC;
      default:                                 m = MASK_NONE;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_if
// Description : Request/response bundle between CPU decode and the ALU
//               sequencer. master = requester, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_carry;
  logic        done;
  logic [15:0] result;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic [3:0]  flag_mask;

  modport master (
    output req_valid, req_op, req_wide, req_a, req_b, req_carry,
    input  req_ready, done, result, flag_n, flag_z, flag_c, flag_v, flag_mask
  );

  modport slave (
    input  req_valid, req_op, req_wide, req_a, req_b, req_carry,
    output req_ready, done, result, flag_n, flag_z, flag_c, flag_v, flag_mask
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 8-bit combinational ALU datapath. One function enable at a
//               time; inv_en_i complements B ahead of the adder (subtract).
// Revision    : 1.0 - initial release
// ============================================================================
module alu (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       carry_i,
  input  logic       sum_en_i,
  input  logic       inv_en_i,
  input  logic       and_en_i,
  input  logic       or_en_i,
  input  logic       eor_en_i,
  input  logic       sr_en_i,
  input  logic       ror_en_i,
  output logic [7:0] y_o,
  output logic       carry_o,
  output logic       overflow_o
);

  logic [7:0] b_eff;
  logic [8:0] sum;

  // Select the enabled function; idle enables give an all-zero output
  always_comb begin
    b_eff      = inv_en_i ? ~b_i : b_i;
    sum        = {1'b0, a_i} + {1'b0, b_eff} + {8'd0, carry_i};
    y_o        = 8'h00;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    if (sum_en_i) begin
      y_o        = sum[7:0];
      carry_o    = sum[8];
      overflow_o = (a_i[7] == b_eff[7]) && (sum[7] != a_i[7]);
    end else if (and_en_i) begin
      y_o = a_i & b_i;
    end else if (or_en_i) begin
      y_o = a_i | b_i;
    end else if (eor_en_i) begin
      y_o = a_i ^ b_i;
    end else if (sr_en_i) begin
      y_o     = {1'b0, a_i[7:1]};
      carry_o = a_i[0];
    end else if (ror_en_i) begin
      y_o     = {carry_i, a_i[7:1]};
      carry_o = a_i[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle controller around the 8-bit alu. Accepts one op
//               per handshake, runs one or two byte passes with chained
//               carry and returns a registered result, flags and flag mask.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter bit WIDE_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  // Latched request and sequencing state
  seq_state_e  state_q;
  logic [3:0]  op_q;
  logic        wide_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        carry_q;   // request C in PASS0, chained carry in PASS1
  logic [7:0]  first_q;   // byte produced by the first of two passes

  // Registered outputs
  logic        done_q;
  logic [15:0] result_q;
  logic        n_q, z_q, c_q, v_q;
  logic [3:0]  mask_q;

  // Pass steering
  logic        hi_first, sel_hi, second;
  logic [7:0]  a_byte, b_byte, alu_b, alu_y;
  logic        alu_cin, alu_cout, alu_ovf;
  logic        sum_en, inv_en, and_en, or_en, eor_en, sr_en, ror_en;

  // Final-pass results
  logic [15:0] res_d;
  logic [3:0]  mask_d;
  logic        n_d, z_d, c_d, v_d;
  logic        last_pass, is_nop;

  // Operand steering and enable decode for the current pass
  always_comb begin
    hi_first = wide_q && ((op_q == OP_LSR) || (op_q == OP_ROR));
    second   = (state_q == ST_PASS1);
    sel_hi   = second ? !hi_first : hi_first;
    a_byte   = sel_hi ? a_q[15:8] : a_q[7:0];
    b_byte   = sel_hi ? b_q[15:8] : b_q[7:0];
    alu_b    = 8'h00;
    alu_cin  = 1'b0;
    sum_en   = 1'b0;
    inv_en   = 1'b0;
    and_en   = 1'b0;
    or_en    = 1'b0;
    eor_en   = 1'b0;
    sr_en    = 1'b0;
    ror_en   = 1'b0;
    if (state_q != ST_IDLE) begin
      case (op_q)
        OP_ADC: begin alu_b = b_byte; alu_cin = carry_q; sum_en = 1'b1; end
        OP_SBC: begin alu_b = b_byte; alu_cin = carry_q; sum_en = 1'b1; inv_en = 1'b1; end
        OP_AND: begin alu_b = b_byte; and_en = 1'b1; end
        OP_ORA: begin alu_b = b_byte; or_en  = 1'b1; end
        OP_EOR: begin alu_b = b_byte; eor_en = 1'b1; end
        OP_ASL: begin alu_b = a_byte; alu_cin = second ? carry_q : 1'b0; sum_en = 1'b1; end
        OP_ROL: begin alu_b = a_byte; alu_cin = carry_q; sum_en = 1'b1; end
        // Wide LSR: the low byte picks up the high byte's shifted-out bit
        OP_LSR: begin
          alu_cin = carry_q;
          if (second) ror_en = 1'b1;
          else        sr_en  = 1'b1;
        end
        OP_ROR: begin alu_cin = carry_q; ror_en = 1'b1; end
        OP_CMP: begin alu_b = b_byte; alu_cin = second ? carry_q : 1'b1; sum_en = 1'b1; inv_en = 1'b1; end
        OP_INC: begin alu_b = 8'h00; alu_cin = second ? carry_q : 1'b1; sum_en = 1'b1; end
        OP_DEC: begin alu_b = 8'hFF; alu_cin = second ? carry_q : 1'b0; sum_en = 1'b1; end
        default: ;
      endcase
    end
  end

  alu u_alu (
    .a_i        (a_byte),
    .b_i        (alu_b),
    .carry_i    (alu_cin),
    .sum_en_i   (sum_en),
    .inv_en_i   (inv_en),
    .and_en_i   (and_en),
    .or_en_i    (or_en),
    .eor_en_i   (eor_en),
    .sr_en_i    (sr_en),
    .ror_en_i   (ror_en),
    .y_o        (alu_y),
    .carry_o    (alu_cout),
    .overflow_o (alu_ovf)
  );

  // Assemble the full result and masked flags for the final pass
  always_comb begin
    if (!wide_q)       res_d = {8'h00, alu_y};
    else if (hi_first) res_d = {first_q, alu_y};
    else               res_d = {alu_y, first_q};
    mask_d    = flag_mask_f(op_q);
    n_d       = mask_d[FM_N] & (wide_q ? res_d[15] : res_d[7]);
    z_d       = mask_d[FM_Z] & (res_d == 16'h0000);
    c_d       = mask_d[FM_C] & alu_cout;
    v_d       = mask_d[FM_V] & alu_ovf;
    last_pass = (state_q == ST_PASS1) || ((state_q == ST_PASS0) && !wide_q);
    is_nop    = (op_q >= 4'd12);
  end

  // Sequencer FSM with registered result, flags and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 4'd0;
      wide_q   <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      carry_q  <= 1'b0;
      first_q  <= 8'h00;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      mask_q   <= MASK_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            wide_q  <= WIDE_EN & bus.req_wide;
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            carry_q <= bus.req_carry;
            state_q <= ST_PASS0;
          end
        end
        ST_PASS0: begin
          if (wide_q) begin
            first_q <= alu_y;
            carry_q <= alu_cout;
            state_q <= ST_PASS1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PASS1: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
      if (last_pass) begin
        done_q <= 1'b1;
        if (is_nop) begin
          mask_q <= MASK_NONE;
        end else begin
          mask_q <= mask_d;
          n_q    <= n_d;
          z_q    <= z_d;
          c_q    <= c_d;
          v_q    <= v_d;
          if (op_q != OP_CMP) result_q <= res_d;
        end
      end
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.flag_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer. Expected responses come
//               from an arithmetic reference model and are queued at accept
//               time; a monitor pops them whenever done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
  import cpu_pkg::*;

  typedef struct {
    logic [15:0] result;
    logic [3:0]  flags;   // {N,Z,C,V}
    logic [3:0]  mask;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [15:0] m_result = 16'h0000;
  logic [3:0]  m_flags  = 4'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer_if bus ();

  alu_sequencer #(.WIDE_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic on 8 or 16 bits
  function automatic exp_t model(input logic [3:0] op, input logic wide,
                                 input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t e;
    int unsigned w, m, sign, ua, ub, s, res, ci;
    logic nc, v, n, z;
    logic [3:0] mask;
    w    = wide ? 16 : 8;
    m    = (32'd1 << w) - 1;
    sign = 32'd1 << (w - 1);
    ua   = {16'd0, a} & m;
    ub   = {16'd0, b} & m;
    ci   = c ? 1 : 0;
    res  = 0; nc = 1'b0; v = 1'b0; mask = 4'b0000;
    case (op)
      4'd0, 4'd1, 4'd9: begin
        if (op != 4'd0) ub = ~ub & m;
        if (op == 4'd9) ci = 1;
        s    = ua + ub + ci;
        res  = s & m;
        nc   = (s >> w) != 0;
        v    = ((ua ^ res) & (ub ^ res) & sign) != 0;
        mask = (op == 4'd9) ? 4'b1110 : 4'b1111;
      end
      4'd2:  begin res = ua & ub; mask = 4'b1100; end
      4'd3:  begin res = ua | ub; mask = 4'b1100; end
      4'd4:  begin res = ua ^ ub; mask = 4'b1100; end
      4'd5:  begin res = (ua << 1) & m;        nc = (ua & sign) != 0; mask = 4'b1110; end
      4'd6:  begin res = ua >> 1;              nc = ua[0];            mask = 4'b1110; end
      4'd7:  begin res = ((ua << 1) | ci) & m; nc = (ua & sign) != 0; mask = 4'b1110; end
      4'd8:  begin res = (ua >> 1) | (c ? sign : 0); nc = ua[0];      mask = 4'b1110; end
      4'd10: begin res = (ua + 1) & m;  mask = 4'b1100; end
      4'd11: begin res = (ua + m) & m;  mask = 4'b1100; end
      default: mask = 4'b0000;
    endcase
    n = (res & sign) != 0;
    z = (res == 0);
    e.result = res[15:0];
    e.flags  = {n, z, nc, v} & mask;
    e.mask   = mask;
    e.cyc    = 0;
    return e;
  endfunction

  // Present one request at a negedge and wait (bounded) for acceptance
  task automatic send(input logic [3:0] op, input logic wide, input logic [15:0] a,
                      input logic [15:0] b, input logic c, input bit hold);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_wide  = wide;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_carry = c;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready) begin
        e = model(op, wide, a, b, c);
        if (op >= 4'd12) begin
          e.result = m_result;
          e.flags  = m_flags;
        end else if (op == 4'd9) begin
          e.result = m_result;
        end
        m_result = e.result;
        m_flags  = e.flags;
        e.cyc    = cyc + 2 + (wide ? 1 : 0);
        q.push_back(e);
        @(negedge clk);
        chk("ready_low_in_pass0", {31'd0, bus.req_ready}, 32'd0);
        if (!hold) bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout: got ready=%0b expected 1 within 20 cycles", bus.req_ready);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_done"},   {31'd0, bus.done}, 32'd0);
    chk({tag, "_result"}, {16'd0, bus.result}, 32'd0);
    chk({tag, "_flags"},  {28'd0, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, 32'd0);
    chk({tag, "_mask"},   {28'd0, bus.flag_mask}, 32'd0);
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got result=%0h expected no done", bus.result);
      end else begin
        mon_e = q.pop_front();
        chk("result",  {16'd0, bus.result}, {16'd0, mon_e.result});
        chk("flags",   {28'd0, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, {28'd0, mon_e.flags});
        chk("mask",    {28'd0, bus.flag_mask}, {28'd0, mon_e.mask});
        chk("latency", cyc, mon_e.cyc);
        chk("ready_with_done", {31'd0, bus.req_ready}, 32'd1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_wide  = 1'b0;
    bus.req_a     = 16'h0000;
    bus.req_b     = 16'h0000;
    bus.req_carry = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors
    send(OP_ADC, 1'b0, 16'h0050, 16'h0050, 1'b0, 1'b0);
    send(OP_ADC, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    send(OP_SBC, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0);
    send(OP_LSR, 1'b1, 16'h0101, 16'h0000, 1'b0, 1'b0);
    send(OP_ADC, 1'b1, 16'h1200, 16'h0034, 1'b0, 1'b0);
    send(OP_CMP, 1'b0, 16'h0040, 16'h0040, 1'b0, 1'b0);
    send(OP_DEC, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
    send(OP_ASL, 1'b1, 16'h8081, 16'h0000, 1'b0, 1'b0);
    send(OP_ROR, 1'b1, 16'h0003, 16'h0000, 1'b1, 1'b0);

    // Back-to-back with valid held, then a pulse during PASS0 that must drop
    send(OP_INC, 1'b0, 16'h007F, 16'h0000, 1'b0, 1'b1);
    send(OP_ASL, 1'b0, 16'h0081, 16'h0000, 1'b0, 1'b0);
    send(OP_INC, 1'b1, 16'h00FF, 16'h0000, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    send(4'hF, 1'b0, 16'h5555, 16'hAAAA, 1'b1, 1'b0);
    drain();

    // Reset during PASS1 of a wide ADC aborts it
    send(OP_ADC, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    if (q.size() != 0) void'(q.pop_back());
    m_result = 16'h0000;
    m_flags  = 4'h0;
    @(negedge clk);
    chk_reset_outputs("abort");
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_late_done", {31'd0, bus.done}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic        wide, c;
      logic [15:0] a, b;
      bit          hold;
      op   = 4'($urandom_range(0, 15));
      wide = 1'($urandom_range(0, 1));
      c    = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      b    = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h0000;
      if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
      hold = ($urandom_range(0, 1) == 1);
      send(op, wide, a, b, c, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
